// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit seven-segment display driver.
// Holds each digit for REFRESH_DIV clocks, scanning digit0..digit3. New data
// goes to a shadow register and becomes active only at a frame boundary, so a
// displayed frame never mixes old and new data.
//
// Load semantics: load is a single-cycle strobe with no back-pressure. Every
// cycle with load=1 captures {din, blank_in, dp_in}; pending reports that the
// shadow holds data not yet shown. A load landing on the frame-boundary cycle
// bypasses the shadow and is shown immediately.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  du,
  output logic        dp,
  output logic [3:0]  bank,
  output logic        pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Hex nibble to active-low segments a..g on bits 6..0.
  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001101;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'ha:    s = 7'b0001000;
      4'hb:    s = 7'b1100000;
      4'hc:    s = 7'b0110001;
      4'hd:    s = 7'b1000010;
      4'he:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic [15:0]      act_d, act_d_nx, sh_d, sh_d_nx;
  logic [3:0]       act_b, act_b_nx, sh_b, sh_b_nx;
  logic [3:0]       act_p, act_p_nx, sh_p, sh_p_nx;
  logic             pend_r, pend_nx;
  logic             tick, frame;
  logic [3:0]       nib_nx;
  logic [6:0]       du_nx;
  logic             dp_nx;
  logic [3:0]       bank_nx;

  // Next-state scan position, shadow/active transfer and output decode.
  always_comb begin
    tick     = (cnt == CNT_LAST);
    frame    = tick && (idx == 2'd3);
    cnt_nx   = tick ? '0 : cnt + 1'b1;
    idx_nx   = tick ? idx + 2'd1 : idx;

    act_d_nx = act_d;
    act_b_nx = act_b;
    act_p_nx = act_p;
    sh_d_nx  = sh_d;
    sh_b_nx  = sh_b;
    sh_p_nx  = sh_p;
    pend_nx  = pend_r;

    if (load) begin
      sh_d_nx = din;
      sh_b_nx = blank_in;
      sh_p_nx = dp_in;
      if (frame) begin
        // Bypass: new data goes straight to the display, older shadow dropped.
        act_d_nx = din;
        act_b_nx = blank_in;
        act_p_nx = dp_in;
        pend_nx  = 1'b0;
      end else begin
        pend_nx  = 1'b1;
      end
    end else if (frame && pend_r) begin
      act_d_nx = sh_d;
      act_b_nx = sh_b;
      act_p_nx = sh_p;
      pend_nx  = 1'b0;
    end

    // Outputs decode from next-state values so bank and du move together.
    nib_nx  = act_d_nx[{idx_nx, 2'b00} +: 4];
    bank_nx = 4'b0001 << idx_nx;
    du_nx   = act_b_nx[idx_nx] ? 7'b1111111 : seg7(nib_nx);
    dp_nx   = ~act_p_nx[idx_nx];
  end

  // State and registered display outputs; reset blanks the display at digit0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 2'd0;
      act_d  <= 16'h0000;
      act_b  <= 4'b1111;
      act_p  <= 4'b0000;
      sh_d   <= 16'h0000;
      sh_b   <= 4'b0000;
      sh_p   <= 4'b0000;
      pend_r <= 1'b0;
      bank   <= 4'b0001;
      du     <= 7'b1111111;
      dp     <= 1'b1;
    end else begin
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      act_d  <= act_d_nx;
      act_b  <= act_b_nx;
      act_p  <= act_p_nx;
      sh_d   <= sh_d_nx;
      sh_b   <= sh_b_nx;
      sh_p   <= sh_p_nx;
      pend_r <= pend_nx;
      bank   <= bank_nx;
      du     <= du_nx;
      dp     <= dp_nx;
    end
  end

  assign pending = pend_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with REFRESH_DIV=4. A reference model derives the
// displayed digit from the number of edges since reset (digit = n/4 mod 4,
// frame boundary when n is a multiple of 16) and pushes the expected outputs
// into a queue; a monitor on the falling edge pops and compares.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  du;
  logic        dp;
  logic [3:0]  bank;
  logic        pending;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .blank_in(blank_in),
    .dp_in(dp_in), .du(du), .dp(dp), .bank(bank), .pending(pending)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [12:0] exp_q[$];
  int          m_n = 0;
  bit          started = 1'b0;
  logic [15:0] m_act_d, m_sh_d;
  logic [3:0]  m_act_b, m_sh_b, m_act_p, m_sh_p;
  bit          m_pend;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001101;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'ha: return 7'b0001000;
      4'hb: return 7'b1100000;
      4'hc: return 7'b0110001;
      4'hd: return 7'b1000010;
      4'he: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  always @(posedge clk) begin
    int          digit;
    logic [3:0]  nib;
    logic [6:0]  e_du;
    logic [3:0]  e_bank;
    logic        e_dp;
    if (rst) begin
      started = 1'b1;
      m_n = 0;
      m_act_d = 16'h0; m_act_b = 4'hf; m_act_p = 4'h0;
      m_sh_d = 16'h0;  m_sh_b = 4'h0;  m_sh_p = 4'h0;
      m_pend = 1'b0;
    end else if (started) begin
      m_n = m_n + 1;
      if (load && (m_n % FRAME == 0)) begin
        m_act_d = din; m_act_b = blank_in; m_act_p = dp_in;
        m_sh_d = din;  m_sh_b = blank_in;  m_sh_p = dp_in;
        m_pend = 1'b0;
      end else if (load) begin
        m_sh_d = din; m_sh_b = blank_in; m_sh_p = dp_in;
        m_pend = 1'b1;
      end else if ((m_n % FRAME == 0) && m_pend) begin
        m_act_d = m_sh_d; m_act_b = m_sh_b; m_act_p = m_sh_p;
        m_pend = 1'b0;
      end
    end
    if (started) begin
      digit  = (m_n / DIV) % 4;
      nib    = 4'((m_act_d >> (4 * digit)) & 16'hf);
      e_bank = 4'(1 << digit);
      e_du   = m_act_b[digit] ? 7'b1111111 : seg_of(nib);
      e_dp   = ~m_act_p[digit];
      exp_q.push_back({e_bank, e_du, e_dp, m_pend});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bank, du, dp, pending} !== e) begin
        errors++;
        $display("FAIL scan t=%0t: got bank=%b du=%b dp=%b pending=%b, want bank=%b du=%b dp=%b pending=%b",
                 $time, bank, du, dp, pending, e[12:9], e[8:2], e[1], e[0]);
      end
      checks++;
      if (!$onehot(bank)) begin
        errors++;
        $display("FAIL onehot t=%0t: got bank=%b, want exactly one bit set", $time, bank);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle(cycles);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    load = 1'b1; din = d; blank_in = b; dp_in = p;
    @(negedge clk);
    load = 1'b0;
    din = 16'($urandom);
  endtask

  // Waits on the falling edge until the model's edge count matches phase
  // within a frame; an expired budget counts as a failed check.
  task automatic wait_phase(input int phase);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_n % FRAME == phase) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_phase: phase %0d not reached, got m_n=%0d", phase, m_n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    @(negedge clk);
    do_reset(2);
    idle(20);

    // Mid-frame load; shown from the next frame boundary.
    wait_phase(6);
    do_load(16'h4B2F, 4'b0000, 4'b0100);
    idle(2 * FRAME);

    // Overwrite before the boundary: only the second value is displayed.
    wait_phase(2);
    do_load(16'h1111, 4'b0000, 4'b0000);
    idle(3);
    do_load(16'h2222, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    // Load on the frame-boundary cycle: bypass.
    wait_phase(FRAME - 1);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    idle(FRAME);

    // Blanked digits 1 and 3.
    wait_phase(3);
    do_load(16'h8888, 4'b1010, 4'b0000);
    idle(2 * FRAME);

    // Reset while pending, on digit2.
    wait_phase(1);
    do_load(16'h7777, 4'b0000, 4'b1111);
    wait_phase(2 * DIV);
    do_reset(1);
    idle(2 * FRAME);

    // Randomized traffic, with occasional resets and boundary-aligned loads.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      rst = (r < 2);
      load = (r >= 2 && r < 16) || (m_n % FRAME == FRAME - 1 && r < 40);
      din = 16'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      dp_in = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst = 1'b0;
    load = 1'b0;
    idle(FRAME);

    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
